// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: accepts a fetch address from the PC stage,
// translates it through the IMMU, reads the instruction bus, and presents the
// fetched word to decode until it is consumed or flushed. Misaligned fetch
// addresses bypass translation and surface as an address-error instruction.
module ifetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid,
  input  logic [31:0] pc_vaddr,
  output logic        pc_ready,
  input  logic        flush,
  input  logic        stall,
  output logic        immu_en,
  output logic [31:0] immu_vaddr,
  input  logic        immu_rdy,
  input  logic [31:0] immu_paddr,
  output logic        ibus_en,
  output logic [31:0] ibus_addr,
  input  logic        ibus_rdy,
  input  logic [31:0] ibus_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  output logic        inst_adel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XLAT,
    S_BUS,
    S_HOLD,
    S_XDRAIN,
    S_BDRAIN
  } state_e;

  state_e      state_q, state_d;
  logic        immu_en_q, immu_en_d;
  logic [31:0] immu_vaddr_q, immu_vaddr_d;
  logic        ibus_en_q, ibus_en_d;
  logic [31:0] ibus_addr_q, ibus_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_adel_q, inst_adel_d;
  logic        accept;

  // Address is only taken when idle and not being flushed in the same cycle.
  always_comb begin
    pc_ready = (state_q == S_IDLE) && !flush;
    accept   = pc_valid && pc_ready;
  end

  // Next-state and registered-output computation; unchanged fields hold.
  always_comb begin
    state_d      = state_q;
    immu_en_d    = immu_en_q;
    immu_vaddr_d = immu_vaddr_q;
    ibus_en_d    = ibus_en_q;
    ibus_addr_d  = ibus_addr_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    inst_d       = inst_q;
    inst_adel_d  = inst_adel_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          inst_pc_d = pc_vaddr;
          if (pc_vaddr[1:0] == 2'b00) begin
            immu_vaddr_d = pc_vaddr;
            immu_en_d    = 1'b1;
            state_d      = S_XLAT;
          end else begin
            inst_valid_d = 1'b1;
            inst_adel_d  = 1'b1;
            inst_d       = '0;
            state_d      = S_HOLD;
          end
        end
      end
      S_XLAT: begin
        // A flush may not drop an open request; it either completes now
        // (result discarded) or is drained before returning idle.
        if (immu_rdy) begin
          immu_en_d = 1'b0;
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            ibus_en_d   = 1'b1;
            ibus_addr_d = immu_paddr;
            state_d     = S_BUS;
          end
        end else if (flush) begin
          state_d = S_XDRAIN;
        end
      end
      S_BUS: begin
        if (ibus_rdy) begin
          ibus_en_d = 1'b0;
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            inst_d       = ibus_rdata;
            inst_valid_d = 1'b1;
            inst_adel_d  = 1'b0;
            state_d      = S_HOLD;
          end
        end else if (flush) begin
          state_d = S_BDRAIN;
        end
      end
      S_HOLD: begin
        if (flush || !stall) begin
          inst_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_XDRAIN: begin
        if (immu_rdy) begin
          immu_en_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_BDRAIN: begin
        if (ibus_rdy) begin
          ibus_en_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      immu_en_q    <= 1'b0;
      immu_vaddr_q <= '0;
      ibus_en_q    <= 1'b0;
      ibus_addr_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      inst_adel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      immu_en_q    <= immu_en_d;
      immu_vaddr_q <= immu_vaddr_d;
      ibus_en_q    <= ibus_en_d;
      ibus_addr_q  <= ibus_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_q       <= inst_d;
      inst_adel_q  <= inst_adel_d;
    end
  end

  // Registered outputs.
  always_comb begin
    immu_en    = immu_en_q;
    immu_vaddr = immu_vaddr_q;
    ibus_en    = ibus_en_q;
    ibus_addr  = ibus_addr_q;
    inst_valid = inst_valid_q;
    inst_pc    = inst_pc_q;
    inst       = inst_q;
    inst_adel  = inst_adel_q;
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed table-driven bench for ifetch_ctrl, with hand sequences for the
// bus-drain flush and asynchronous reset corner cases.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_valid = 1'b0;
  logic [31:0] pc_vaddr = '0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        immu_en;
  logic [31:0] immu_vaddr;
  logic        immu_rdy = 1'b0;
  logic [31:0] immu_paddr = '0;
  logic        ibus_en;
  logic [31:0] ibus_addr;
  logic        ibus_rdy = 1'b0;
  logic [31:0] ibus_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        inst_adel;

  int total = 0;
  int bad   = 0;

  ifetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_valid   (pc_valid),
    .pc_vaddr   (pc_vaddr),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .stall      (stall),
    .immu_en    (immu_en),
    .immu_vaddr (immu_vaddr),
    .immu_rdy   (immu_rdy),
    .immu_paddr (immu_paddr),
    .ibus_en    (ibus_en),
    .ibus_addr  (ibus_addr),
    .ibus_rdy   (ibus_rdy),
    .ibus_rdata (ibus_rdata),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .inst       (inst),
    .inst_adel  (inst_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] va;
    logic        fl;
    logic        st;
    logic        mr;
    logic [31:0] pa;
    logic        br;
    logic [31:0] rd;
    logic        e_rdy;
    logic        e_men;
    logic [31:0] e_mva;
    logic        e_ben;
    logic [31:0] e_bad;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_inst;
    logic        e_adel;
  } vec_t;

  function automatic vec_t mk(
    input logic pv, input logic [31:0] va, input logic fl, input logic st,
    input logic mr, input logic [31:0] pa, input logic br, input logic [31:0] rd,
    input logic er, input logic em, input logic [31:0] emv, input logic eb,
    input logic [31:0] eba, input logic eiv, input logic [31:0] eipc,
    input logic [31:0] einst, input logic eadel);
    vec_t v;
    v.pv = pv; v.va = va; v.fl = fl; v.st = st;
    v.mr = mr; v.pa = pa; v.br = br; v.rd = rd;
    v.e_rdy = er; v.e_men = em; v.e_mva = emv; v.e_ben = eb; v.e_bad = eba;
    v.e_iv = eiv; v.e_ipc = eipc; v.e_inst = einst; v.e_adel = eadel;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input vec_t v, input string tag);
    chk({tag, ".immu_en"},    {31'd0, immu_en},    {31'd0, v.e_men});
    chk({tag, ".immu_vaddr"}, immu_vaddr,          v.e_mva);
    chk({tag, ".ibus_en"},    {31'd0, ibus_en},    {31'd0, v.e_ben});
    chk({tag, ".ibus_addr"},  ibus_addr,           v.e_bad);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, v.e_iv});
    chk({tag, ".inst_pc"},    inst_pc,             v.e_ipc);
    chk({tag, ".inst"},       inst,                v.e_inst);
    chk({tag, ".inst_adel"},  {31'd0, inst_adel},  {31'd0, v.e_adel});
    chk({tag, ".en_excl"},    {31'd0, immu_en & ibus_en}, 32'd0);
  endtask

  // Drive one cycle of inputs at the falling edge, check pc_ready before the
  // rising edge and registered outputs just after it.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    pc_valid   = v.pv;
    pc_vaddr   = v.va;
    flush      = v.fl;
    stall      = v.st;
    immu_rdy   = v.mr;
    immu_paddr = v.pa;
    ibus_rdy   = v.br;
    ibus_rdata = v.rd;
    #1;
    chk({tag, ".pc_ready"}, {31'd0, pc_ready}, {31'd0, v.e_rdy});
    @(posedge clk);
    #1;
    chk_out(v, tag);
  endtask

  vec_t tbl[$];
  vec_t zero_v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset-state check
    #1 rst = 1'b0;
    #1;
    zero_v = mk(0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0);
    chk("reset.pc_ready", {31'd0, pc_ready}, 32'd1);
    chk_out(zero_v, "reset");
    @(negedge clk);
    rst = 1'b1;

    // Aligned fetch, minimum latency
    tbl.push_back(mk(1,32'hBFC00000,0,0,0,0,0,0,                 1,1,32'hBFC00000,0,0,0,32'hBFC00000,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'h1FC00000,0,0,                 0,0,32'hBFC00000,1,32'h1FC00000,0,32'hBFC00000,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,32'h3C1D8000,                 0,0,32'hBFC00000,0,32'h1FC00000,1,32'hBFC00000,32'h3C1D8000,0));
    tbl.push_back(mk(1,32'h80009000,0,0,0,0,0,0,                 0,0,32'hBFC00000,0,32'h1FC00000,0,32'hBFC00000,32'h3C1D8000,0));
    // Misaligned fetch
    tbl.push_back(mk(1,32'h80000002,0,0,0,0,0,0,                 1,0,32'hBFC00000,0,32'h1FC00000,1,32'h80000002,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                            0,0,32'hBFC00000,0,32'h1FC00000,0,32'h80000002,0,1));
    // Fetch held by 3 stall cycles, handshake noise ignored while holding
    tbl.push_back(mk(1,32'h80001000,0,0,0,0,0,0,                 1,1,32'h80001000,0,32'h1FC00000,0,32'h80001000,0,1));
    tbl.push_back(mk(0,0,0,0,1,32'h00001000,0,0,                 0,0,32'h80001000,1,32'h00001000,0,32'h80001000,0,1));
    tbl.push_back(mk(0,0,0,1,0,0,1,32'hDEADBEEF,                 0,0,32'h80001000,0,32'h00001000,1,32'h80001000,32'hDEADBEEF,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,32'h80000010,0,1,1,32'hFFFF0000,1,32'h11111111, 0,0,32'h80001000,0,32'h00001000,1,32'h80001000,32'hDEADBEEF,0));
    tbl.push_back(mk(1,32'h8000A000,0,0,0,0,0,0,                 0,0,32'h80001000,0,32'h00001000,0,32'h80001000,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                            1,0,32'h80001000,0,32'h00001000,0,32'h80001000,32'hDEADBEEF,0));
    // Flush coincident with immu_rdy
    tbl.push_back(mk(1,32'h80002000,0,0,0,0,0,0,                 1,1,32'h80002000,0,32'h00001000,0,32'h80002000,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,1,0,1,32'h00002000,0,0,                 0,0,32'h80002000,0,32'h00001000,0,32'h80002000,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                            1,0,32'h80002000,0,32'h00001000,0,32'h80002000,32'hDEADBEEF,0));
    // Flush while idle blocks acceptance
    tbl.push_back(mk(1,32'h80003000,1,0,0,0,0,0,                 0,0,32'h80002000,0,32'h00001000,0,32'h80002000,32'hDEADBEEF,0));
    // Flush in XLAT without immu_rdy -> drain
    tbl.push_back(mk(1,32'h80004000,0,0,0,0,0,0,                 1,1,32'h80004000,0,32'h00001000,0,32'h80004000,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,1,0,0,0,0,0,                            0,1,32'h80004000,0,32'h00001000,0,32'h80004000,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,1,0,0,0,0,0,                            0,1,32'h80004000,0,32'h00001000,0,32'h80004000,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,0,0,1,32'h00004000,0,0,                 0,0,32'h80004000,0,32'h00001000,0,32'h80004000,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                            1,0,32'h80004000,0,32'h00001000,0,32'h80004000,32'hDEADBEEF,0));
    // Flush in HOLD overrides stall
    tbl.push_back(mk(1,32'h80005001,0,0,0,0,0,0,                 1,0,32'h80004000,0,32'h00001000,1,32'h80005001,0,1));
    tbl.push_back(mk(0,0,1,1,0,0,0,0,                            0,0,32'h80004000,0,32'h00001000,0,32'h80005001,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                            1,0,32'h80004000,0,32'h00001000,0,32'h80005001,0,1));
    // Flush coincident with ibus_rdy discards data
    tbl.push_back(mk(1,32'h80006000,0,0,0,0,0,0,                 1,1,32'h80006000,0,32'h00001000,0,32'h80006000,0,1));
    tbl.push_back(mk(0,0,0,0,1,32'h00006000,0,0,                 0,0,32'h80006000,1,32'h00006000,0,32'h80006000,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,1,32'h12345678,                 0,0,32'h80006000,0,32'h00006000,0,32'h80006000,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                            1,0,32'h80006000,0,32'h00006000,0,32'h80006000,0,1));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("v%0d", i));

    // Flush in BUS with ibus_rdy delayed: ibus_en held 4 cycles, then idle
    apply(mk(1,32'h8000B000,0,0,0,0,0,0,     1,1,32'h8000B000,0,32'h00006000,0,32'h8000B000,0,1), "bd.acc");
    apply(mk(0,0,0,0,1,32'h0000B000,0,0,     0,0,32'h8000B000,1,32'h0000B000,0,32'h8000B000,0,1), "bd.xlat");
    apply(mk(0,0,1,0,0,0,0,0,                0,0,32'h8000B000,1,32'h0000B000,0,32'h8000B000,0,1), "bd.flush");
    for (int i = 0; i < 3; i++)
      apply(mk(0,0,0,0,0,0,0,0,              0,0,32'h8000B000,1,32'h0000B000,0,32'h8000B000,0,1), $sformatf("bd.wait%0d", i));
    apply(mk(0,0,0,0,0,0,1,32'hCAFEF00D,     0,0,32'h8000B000,0,32'h0000B000,0,32'h8000B000,0,1), "bd.rdy");
    apply(mk(0,0,0,0,0,0,0,0,                1,0,32'h8000B000,0,32'h0000B000,0,32'h8000B000,0,1), "bd.idle");

    // Asynchronous reset in XLAT, then a normal fetch
    apply(mk(1,32'h8000C000,0,0,0,0,0,0,     1,1,32'h8000C000,0,32'h0000B000,0,32'h8000C000,0,1), "ar.acc");
    #2 rst = 1'b0;
    #1;
    chk("ar.pc_ready", {31'd0, pc_ready}, 32'd1);
    chk_out(zero_v, "ar.async");
    @(negedge clk);
    pc_valid = 1'b0;
    rst = 1'b1;
    apply(mk(1,32'h8000D000,0,0,0,0,0,0,     1,1,32'h8000D000,0,0,0,32'h8000D000,0,0), "ar.f0");
    apply(mk(0,0,0,0,1,32'h0000D000,0,0,     0,0,32'h8000D000,1,32'h0000D000,0,32'h8000D000,0,0), "ar.f1");
    apply(mk(0,0,0,0,0,0,1,32'hAABBCCDD,     0,0,32'h8000D000,0,32'h0000D000,1,32'h8000D000,32'hAABBCCDD,0), "ar.f2");
    apply(mk(0,0,0,0,0,0,0,0,                0,0,32'h8000D000,0,32'h0000D000,0,32'h8000D000,32'hAABBCCDD,0), "ar.f3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-003 SHALL have ports: pc_valid  in  1  PC stage offers a fetch address.
REQ-004 SHALL have ports: pc_vaddr  in  32  virtual fetch address.
REQ-005 SHALL have ports: pc_ready  out  1  address accepted this cycle.
REQ-006 SHALL have ports: flush  in  1  cancel current fetch (branch/exception).
REQ-007 SHALL have ports: stall  in  1  decode cannot consume inst this cycle.
REQ-008 SHALL have ports: immu_en  out  1; immu_vaddr  out  32; immu_rdy  in  1; immu_paddr  in  32  (translation handshake to TLBU).
REQ-009 SHALL have ports: ibus_en  out  1; ibus_addr  out  32; ibus_rdy  in  1; ibus_rdata  in  32  (instruction bus read).
REQ-010 SHALL have ports: inst_valid  out  1; inst_pc  out  32; inst  out  32; inst_adel  out  1  (to decode).

Function
REQ-011 SHALL implement states IDLE, XLAT, BUS, HOLD, XDRAIN, BDRAIN; all outputs registered except pc_ready.
REQ-012 SHALL drive pc_ready = 1 only when state is IDLE and flush = 0.
REQ-013 IDLE, pc_valid & pc_ready, pc_vaddr[1:0] = 0: SHALL latch pc_vaddr into inst_pc and immu_vaddr, set immu_en = 1, go XLAT.
REQ-014 IDLE, pc_valid & pc_ready, pc_vaddr[1:0] != 0: SHALL latch inst_pc, set inst_valid = 1, inst_adel = 1, inst = 0, go HOLD; no immu_en or ibus_en issued.
REQ-015 XLAT: immu_en and immu_vaddr SHALL stay stable until immu_rdy sampled 1; then immu_en = 0, ibus_en = 1, ibus_addr = immu_paddr, go BUS.
REQ-016 BUS: ibus_en and ibus_addr SHALL stay stable until ibus_rdy sampled 1; then ibus_en = 0, inst = ibus_rdata, inst_valid = 1, inst_adel = 0, go HOLD.
REQ-017 HOLD: inst_valid, inst, inst_pc, inst_adel SHALL hold while stall = 1; on a cycle with stall = 0, inst_valid SHALL clear at that edge and state go IDLE.
REQ-018 Minimum latency: accept at edge N, immu_rdy and ibus_rdy each high on first opportunity -> inst_valid = 1 after edge N+2.
REQ-019 flush in XLAT with immu_rdy = 0: SHALL go XDRAIN keeping immu_en = 1; XDRAIN on immu_rdy = 1 -> immu_en = 0, IDLE, paddr discarded.
REQ-020 flush in BUS with ibus_rdy = 0: SHALL go BDRAIN keeping ibus_en = 1; BDRAIN on ibus_rdy = 1 -> ibus_en = 0, IDLE, data discarded.
REQ-021 flush coincident with immu_rdy (XLAT) or ibus_rdy (BUS): SHALL complete handshake, discard result, go IDLE directly; flush has priority over result use.
REQ-022 flush in HOLD: SHALL clear inst_valid at that edge and go IDLE regardless of stall.
REQ-023 flush in IDLE: no address accepted (pc_ready = 0); state stays IDLE.
REQ-024 flush in XDRAIN/BDRAIN: no additional effect.
REQ-025 immu_en and ibus_en SHALL never be 1 simultaneously; inst_valid SHALL never be 1 outside HOLD.

Reset
REQ-026 rst = 0 SHALL immediately force state IDLE and all registered outputs to 0 (immu_en, immu_vaddr, ibus_en, ibus_addr, inst_valid, inst_pc, inst, inst_adel), independent of clk.
REQ-027 Reset mid-fetch SHALL abandon any outstanding handshake; after rst returns to 1, first edge with pc_valid = 1 is accepted.

Verification
REQ-028 pc_vaddr = 0xBFC00000, immu_rdy same-cycle, immu_paddr = 0x1FC00000, ibus_rdy next cycle with rdata = 0x3C1D8000 -> ibus_addr = 0x1FC00000, inst_valid after edge N+2, inst = 0x3C1D8000, inst_pc = 0xBFC00000.
REQ-029 pc_vaddr = 0x80000002 -> no immu_en/ibus_en, next cycle inst_valid = 1, inst_adel = 1, inst = 0, inst_pc = 0x80000002.
REQ-030 Completed fetch with stall = 1 for 3 cycles -> inst_valid and inst stable for 3 cycles, clears after first stall = 0 edge; pc_ready = 1 only afterwards.
REQ-031 flush during BUS, ibus_rdy delayed 4 cycles -> ibus_en held 4 cycles, ibus_addr unchanged, no inst_valid, pc_ready = 1 cycle after ibus_rdy.
REQ-032 flush same cycle as immu_rdy = 1 -> ibus_en never asserted, IDLE next cycle.
REQ-033 rst = 0 asynchronously during XLAT -> immu_en = 0 and all outputs 0 before next clk edge; normal fetch after release.
